// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master bridge.
// Turns a command/response handshake interface into one AXI4-Lite write or
// read transaction at a time. All outputs are registered and driven from a
// single state machine.
module axi4_lite_master_bridge #(
  parameter int unsigned p_ADDRESS_WIDTH = 2,
  parameter int unsigned p_DATA_WIDTH    = 8
) (
  input  logic                        i_ACLK,
  input  logic                        i_ARESETN,
  // command side
  input  logic                        i_CMD_VALID,
  output logic                        o_CMD_READY,
  input  logic                        i_CMD_WRITE,
  input  logic [p_ADDRESS_WIDTH-1:0]  i_CMD_ADDR,
  input  logic [p_DATA_WIDTH-1:0]     i_CMD_WDATA,
  // response side
  output logic                        o_RSP_VALID,
  input  logic                        i_RSP_READY,
  output logic [p_DATA_WIDTH-1:0]     o_RSP_RDATA,
  output logic [1:0]                  o_RSP_RESP,
  // AXI4-Lite write address channel
  output logic [p_ADDRESS_WIDTH-1:0]  o_M_AWADDR,
  output logic                        o_M_AWVALID,
  input  logic                        i_S_AWREADY,
  // AXI4-Lite write data channel
  output logic [p_DATA_WIDTH-1:0]     o_M_WDATA,
  output logic [p_DATA_WIDTH/8-1:0]   o_M_WSTRB,
  output logic                        o_M_WVALID,
  input  logic                        i_S_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]                  i_S_BRESP,
  input  logic                        i_S_BVALID,
  output logic                        o_M_BREADY,
  // AXI4-Lite read address channel
  output logic [p_ADDRESS_WIDTH-1:0]  o_M_ARADDR,
  output logic                        o_M_ARVALID,
  input  logic                        i_S_ARREADY,
  // AXI4-Lite read data channel
  input  logic [p_DATA_WIDTH-1:0]     i_S_RDATA,
  input  logic [1:0]                  i_S_RRESP,
  input  logic                        i_S_RVALID,
  output logic                        o_M_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t                      state;
  logic                        aw_done;
  logic                        w_done;
  logic [p_ADDRESS_WIDTH-1:0]  addr;
  logic [p_DATA_WIDTH-1:0]     wdata;

  logic                        cmd_fire;
  logic                        rsp_fire;
  logic                        aw_fire;
  logic                        w_fire;
  logic                        b_fire;
  logic                        ar_fire;
  logic                        r_fire;
  logic                        aw_done_next;
  logic                        w_done_next;

  // One latched address serves both AW and AR; only one of them is ever valid.
  assign o_M_AWADDR = addr;
  assign o_M_ARADDR = addr;
  assign o_M_WDATA  = wdata;
  assign o_M_WSTRB  = '1;

  assign cmd_fire = i_CMD_VALID & o_CMD_READY;
  assign rsp_fire = o_RSP_VALID & i_RSP_READY;
  assign aw_fire  = o_M_AWVALID & i_S_AWREADY;
  assign w_fire   = o_M_WVALID & i_S_WREADY;
  assign b_fire   = i_S_BVALID & o_M_BREADY;
  assign ar_fire  = o_M_ARVALID & i_S_ARREADY;
  assign r_fire   = i_S_RVALID & o_M_RREADY;

  // AW and W complete independently; both may finish on the same edge.
  assign aw_done_next = aw_done | aw_fire;
  assign w_done_next  = w_done | w_fire;

  // Transaction sequencer; every handshake output is a register.
  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      o_CMD_READY <= 1'b0;
      o_RSP_VALID <= 1'b0;
      o_RSP_RDATA <= '0;
      o_RSP_RESP  <= '0;
      o_M_AWVALID <= 1'b0;
      o_M_WVALID  <= 1'b0;
      o_M_BREADY  <= 1'b0;
      o_M_ARVALID <= 1'b0;
      o_M_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Ready rises on the first edge after reset release.
          o_CMD_READY <= 1'b1;
          if (cmd_fire) begin
            addr        <= i_CMD_ADDR;
            wdata       <= i_CMD_WDATA;
            o_CMD_READY <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            if (i_CMD_WRITE) begin
              o_M_AWVALID <= 1'b1;
              o_M_WVALID  <= 1'b1;
              state       <= WR_ADDR_DATA;
            end else begin
              o_M_ARVALID <= 1'b1;
              state       <= RD_ADDR;
            end
          end
        end

        WR_ADDR_DATA: begin
          if (aw_fire) begin
            o_M_AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_fire) begin
            o_M_WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_done_next && w_done_next) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            o_M_BREADY <= 1'b1;
            state      <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (b_fire) begin
            o_RSP_RESP  <= i_S_BRESP;
            o_RSP_RDATA <= '0;
            o_M_BREADY  <= 1'b0;
            o_RSP_VALID <= 1'b1;
            state       <= RESP;
          end
        end

        RD_ADDR: begin
          if (ar_fire) begin
            o_M_ARVALID <= 1'b0;
            o_M_RREADY  <= 1'b1;
            state       <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (r_fire) begin
            o_RSP_RDATA <= i_S_RDATA;
            o_RSP_RESP  <= i_S_RRESP;
            o_M_RREADY  <= 1'b0;
            o_RSP_VALID <= 1'b1;
            state       <= RESP;
          end
        end

        RESP: begin
          // Command ready returns one cycle after the response handshake.
          if (rsp_fire) begin
            o_RSP_VALID <= 1'b0;
            o_CMD_READY <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
